// File: rtl/shift_sub_div_if.sv
// Start/done handshake bundle between the FP divide sequencer (master)
// and the shift-subtract divider (slave).
// Optional: define DIV_STICKY_EN to add the sticky (remainder != 0) signal.
interface shift_sub_div_if #(
    parameter int unsigned WIDTH = 24
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
`ifdef DIV_STICKY_EN
    logic             sticky;
`endif

`ifdef DIV_STICKY_EN
    modport master (output start, x, y, input busy, done, q, r, dz, sticky);
    modport slave  (input start, x, y, output busy, done, q, r, dz, sticky);
`else
    modport master (output start, x, y, input busy, done, q, r, dz);
    modport slave  (input start, x, y, output busy, done, q, r, dz);
`endif
endinterface

// File: rtl/shift_sub_div.sv
// Sequential restoring divider (shift-subtract), one quotient bit per clock.
// Produces mantissa quotient/remainder for the FP divide path.
// Optional: define DIV_STICKY_EN to register sticky = (final remainder != 0).
module shift_sub_div #(
    parameter int unsigned WIDTH = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_sub_div_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder R
    logic [WIDTH-1:0] quo_q, quo_d;   // dividend/quotient shift register Q
    logic [WIDTH-1:0] div_q, div_d;   // captured divisor D
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
`ifdef DIV_STICKY_EN
    logic             sticky_q, sticky_d;
`endif

    // Next-state, datapath iteration and registered-output computation.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
`ifdef DIV_STICKY_EN
        sticky_d = sticky_q;
`endif
        trial = {rem_q, quo_q[WIDTH-1]};
        diff  = trial - {1'b0, div_q};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.y != '0) begin
                        rem_d   = '0;
                        quo_d   = bus.x;
                        div_d   = bus.y;
                        cnt_d   = CW'(WIDTH);
                        state_d = CALC;
                    end else begin
                        q_d     = '1;
                        r_d     = bus.x;
                        dz_d    = 1'b1;
`ifdef DIV_STICKY_EN
                        sticky_d = 1'b0;
`endif
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    q_d     = quo_d;
                    r_d     = rem_d;
                    dz_d    = 1'b0;
`ifdef DIV_STICKY_EN
                    sticky_d = (rem_d != '0);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up with it.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers; synchronous active-low reset aborts any operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
`ifdef DIV_STICKY_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
`ifdef DIV_STICKY_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.dz   = dz_q;
`ifdef DIV_STICKY_EN
    assign bus.sticky = sticky_q;
`endif
endmodule

// File: tb/tb_shift_sub_div.sv
// Self-checking bench for shift_sub_div: directed cases plus random operands,
// compared against plain integer division. Handles DIV_STICKY_EN builds.
module tb_shift_sub_div;
    localparam int unsigned W = 24;
    localparam logic [W-1:0] ONES = '1;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [W-1:0] prev_q;
    logic [W-1:0] prev_r;

    shift_sub_div_if #(.WIDTH(W)) bus ();

    shift_sub_div #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Run one division; when hold is set, start stays asserted and the
    // operands are scrambled every cycle while the divider is busy.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] ya, input bit hold, input string tag);
        logic [W-1:0] eq, er;
        int  edges, busy_cnt;
        bit  got;
        if (ya == 0) begin
            eq = ONES;
            er = xa;
        end else begin
            eq = xa / ya;
            er = xa % ya;
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.x     = xa;
        bus.y     = ya;
        @(posedge clk);
        #1;
        busy_cnt = bus.busy ? 1 : 0;
        edges = 0;
        got = bus.done;
        if (!got) begin
            check_eq({tag, "_stale_q"}, 64'(bus.q), 64'(prev_q));
            check_eq({tag, "_stale_r"}, 64'(bus.r), 64'(prev_r));
        end
        while (!got && edges < int'(W) + 8) begin
            @(negedge clk);
            if (hold) begin
                bus.start = 1'b1;
                bus.x = W'($urandom);
                bus.y = W'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
            if (bus.busy) busy_cnt++;
            if (bus.done) got = 1'b1;
        end
        check_eq({tag, "_done_seen"}, 64'(got), 64'd1);
        check_eq({tag, "_latency"}, 64'(edges), (ya == 0) ? 64'd0 : 64'(W));
        check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), (ya == 0) ? 64'd1 : 64'(W + 1));
        check_eq({tag, "_q"}, 64'(bus.q), 64'(eq));
        check_eq({tag, "_r"}, 64'(bus.r), 64'(er));
        check_eq({tag, "_dz"}, 64'(bus.dz), 64'(ya == 0));
        if (ya != 0)
            check_eq({tag, "_law"}, 64'(bus.q) * 64'(ya) + 64'(bus.r), 64'(xa));
`ifdef DIV_STICKY_EN
        check_eq({tag, "_sticky"}, 64'(bus.sticky), 64'((ya != 0) && (er != 0)));
`endif
        prev_q = eq;
        prev_r = er;
        // done must drop after one cycle and start is ignored while in DONE
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        @(posedge clk);
        #1;
        check_eq({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        check_eq({tag, "_idle_after"}, 64'(bus.busy), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rx, ry;
        bit seen_done;
        n_checks = 0;
        n_fail = 0;
        prev_q = '0;
        prev_r = '0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.x = '0;
        bus.y = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_q", 64'(bus.q), 64'd0);
        check_eq("rst_r", 64'(bus.r), 64'd0);
        check_eq("rst_dz", 64'(bus.dz), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(W'(100), W'(7), 1'b0, "basic");
        do_op(W'(24'hC00000), W'(24'h800000), 1'b0, "mant");
        do_op(W'(24'hFFFFFF), W'(1), 1'b0, "max_by1");
        do_op(W'(5), W'(9), 1'b0, "small");
        do_op(W'(24'h123456), W'(0), 1'b0, "divzero");
        do_op(W'(9), W'(3), 1'b0, "after_dz");
        do_op(W'(24'hFFFFFF), W'(24'hFFFFFF), 1'b0, "equal");
        do_op(W'(1000), W'(33), 1'b1, "hold");
        do_op(W'(77), W'(5), 1'b0, "after_hold");

        // Reset mid-operation: abort with no done pulse.
        @(negedge clk);
        bus.start = 1'b1;
        bus.x = W'(100);
        bus.y = W'(7);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_busy", 64'(bus.busy), 64'd0);
        check_eq("midrst_done", 64'(bus.done), 64'd0);
        check_eq("midrst_q", 64'(bus.q), 64'd0);
        check_eq("midrst_r", 64'(bus.r), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (W + 6) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done = 1'b1;
        end
        check_eq("midrst_no_done", 64'(seen_done), 64'd0);
        prev_q = '0;
        prev_r = '0;
        do_op(W'(50), W'(6), 1'b0, "post_rst");

        // Random operands, including zero and small divisors.
        for (int i = 0; i < 24; i++) begin
            rx = W'($urandom);
            case ($urandom_range(0, 3))
                0: ry = W'($urandom_range(0, 3));
                1: ry = W'($urandom_range(1, 255));
                default: ry = W'($urandom);
            endcase
            do_op(rx, ry, ($urandom_range(0, 3) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
